// File: rtl/reg_file_sb.sv
// Integer register file with two write ports, same-cycle write-to-read bypass,
// and a load scoreboard (per-register busy bits plus a bounded outstanding-load count).
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int MAX_LD   = 4
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic [RD_PORTS*ADDR_W-1:0] iRdAddr,
  output logic [RD_PORTS*DATA_W-1:0] oRdData,
  output logic [RD_PORTS-1:0]        oRdBusy,
  input  logic                       iWrEn0,
  input  logic [ADDR_W-1:0]          iWrAddr0,
  input  logic [DATA_W-1:0]          iWrData0,
  input  logic                       iWrEn1,
  input  logic [ADDR_W-1:0]          iWrAddr1,
  input  logic [DATA_W-1:0]          iWrData1,
  input  logic                       iLdIssue,
  input  logic [ADDR_W-1:0]          iLdDest,
  output logic                       oLdFull,
  output logic                       oErr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_LD + 1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              ld_full_s;
  logic              ld_accept_s;
  logic              wr0_nz_s;
  logic              wr1_nz_s;
  logic [ADDR_W-1:0] rd_addr_s [RD_PORTS];

  assign ld_full_s   = (cnt_q == CNT_W'(MAX_LD));
  assign ld_accept_s = iLdIssue & ~ld_full_s;
  assign wr0_nz_s    = iWrEn0 & (iWrAddr0 != '0);
  assign wr1_nz_s    = iWrEn1 & (iWrAddr1 != '0);

  // Next-state for storage, busy bits, outstanding-load count and error flag
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      // Port 1 (load return) takes priority when both ports hit the same register.
      regs_d[i] = (wr1_nz_s && iWrAddr1 == ADDR_W'(i)) ? iWrData1 :
                  (wr0_nz_s && iWrAddr0 == ADDR_W'(i)) ? iWrData0 : regs_q[i];
      busy_d[i] = (ld_accept_s && iLdDest == ADDR_W'(i)) |
                  (busy_q[i] & ~(wr1_nz_s && iWrAddr1 == ADDR_W'(i)));
    end
    case ({ld_accept_s, iWrEn1})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q
          | (iLdIssue & ld_full_s)
          | (iWrEn1 & (cnt_q == '0))
          | (wr1_nz_s & ~busy_q[iWrAddr1]);
  end

  // State registers with synchronous reset that discards same-cycle writes and issues
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Combinational read ports with write bypass; a returning load also masks busy
  always_comb begin
    oRdData = '0;
    oRdBusy = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_addr_s[p] = iRdAddr[p*ADDR_W +: ADDR_W];
      if (rd_addr_s[p] == '0) begin
        oRdData[p*DATA_W +: DATA_W] = '0;
      end else if (wr1_nz_s && iWrAddr1 == rd_addr_s[p]) begin
        oRdData[p*DATA_W +: DATA_W] = iWrData1;
      end else if (wr0_nz_s && iWrAddr0 == rd_addr_s[p]) begin
        oRdData[p*DATA_W +: DATA_W] = iWrData0;
      end else begin
        oRdData[p*DATA_W +: DATA_W] = regs_q[rd_addr_s[p]];
      end
      oRdBusy[p] = busy_q[rd_addr_s[p]] & ~(iWrEn1 && iWrAddr1 == rd_addr_s[p]);
    end
  end

  assign oLdFull = ld_full_s;
  assign oErr    = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: hand-computed expectations checked with immediate assertions.
module tb_reg_file_sb;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [9:0]  iRdAddr;
  logic [63:0] oRdData;
  logic [1:0]  oRdBusy;
  logic        iWrEn0;
  logic [4:0]  iWrAddr0;
  logic [31:0] iWrData0;
  logic        iWrEn1;
  logic [4:0]  iWrAddr1;
  logic [31:0] iWrData1;
  logic        iLdIssue;
  logic [4:0]  iLdDest;
  logic        oLdFull;
  logic        oErr;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .MAX_LD(4)) dut (
    .iClk(iClk), .iRst(iRst), .iRdAddr(iRdAddr), .oRdData(oRdData), .oRdBusy(oRdBusy),
    .iWrEn0(iWrEn0), .iWrAddr0(iWrAddr0), .iWrData0(iWrData0),
    .iWrEn1(iWrEn1), .iWrAddr1(iWrAddr1), .iWrData1(iWrData1),
    .iLdIssue(iLdIssue), .iLdDest(iLdDest), .oLdFull(oLdFull), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle();
    iWrEn0 = 1'b0; iWrAddr0 = 5'd0; iWrData0 = 32'd0;
    iWrEn1 = 1'b0; iWrAddr1 = 5'd0; iWrData1 = 32'd0;
    iLdIssue = 1'b0; iLdDest = 5'd0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    iRdAddr = {a1, a0};
    #1;
  endtask

  task automatic issue(input logic [4:0] dest);
    idle();
    iLdIssue = 1'b1; iLdDest = dest;
    tick();
    idle();
  endtask

  task automatic ret(input logic [4:0] addr, input logic [31:0] data);
    idle();
    iWrEn1 = 1'b1; iWrAddr1 = addr; iWrData1 = data;
    tick();
    idle();
  endtask

  initial begin
    idle();
    iRdAddr = 10'd0;
    iRst    = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
    #1;

    // 1: reset state across all registers
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check($sformatf("rst_rd0_x%0d", i), oRdData[31:0], 32'd0);
      check($sformatf("rst_rd1_x%0d", 31 - i), oRdData[63:32], 32'd0);
      check($sformatf("rst_busy_x%0d", i), {30'd0, oRdBusy}, 32'd0);
    end
    check("rst_full", {31'd0, oLdFull}, 32'd0);
    check("rst_err", {31'd0, oErr}, 32'd0);

    // 2: port-0 write with bypass, then x0 ignores writes
    iWrEn0 = 1'b1; iWrAddr0 = 5'd5; iWrData0 = 32'hDEADBEEF;
    rd(5'd5, 5'd5);
    check("byp0_p0", oRdData[31:0], 32'hDEADBEEF);
    check("byp0_p1", oRdData[63:32], 32'hDEADBEEF);
    tick(); idle(); #1;
    check("x5_stored", oRdData[31:0], 32'hDEADBEEF);
    iWrEn0 = 1'b1; iWrAddr0 = 5'd0; iWrData0 = 32'h1;
    rd(5'd0, 5'd0);
    check("x0_byp", oRdData[31:0], 32'd0);
    tick(); idle(); #1;
    check("x0_stored", oRdData[63:32], 32'd0);

    // 3: load to x7, then return with bypass and busy masking
    issue(5'd7);
    rd(5'd7, 5'd5);
    check("x7_busy", {30'd0, oRdBusy}, 32'd1);
    iWrEn1 = 1'b1; iWrAddr1 = 5'd7; iWrData1 = 32'h55;
    rd(5'd7, 5'd7);
    check("x7_ret_data", oRdData[31:0], 32'h55);
    check("x7_ret_busy", {30'd0, oRdBusy}, 32'd0);
    tick(); idle(); #1;
    check("x7_after", oRdData[63:32], 32'h55);
    check("x7_busy_after", {30'd0, oRdBusy}, 32'd0);
    check("x7_err", {31'd0, oErr}, 32'd0);

    // 4: fill the load queue, then overflow
    issue(5'd1); issue(5'd2); issue(5'd3);
    check("full_at3", {31'd0, oLdFull}, 32'd0);
    issue(5'd4);
    check("full_at4", {31'd0, oLdFull}, 32'd1);
    rd(5'd1, 5'd4);
    check("busy_x1_x4", {30'd0, oRdBusy}, 32'd3);
    issue(5'd5);
    check("ovf_err", {31'd0, oErr}, 32'd1);
    check("ovf_full", {31'd0, oLdFull}, 32'd1);
    rd(5'd5, 5'd5);
    check("ovf_x5_busy", {30'd0, oRdBusy}, 32'd0);
    ret(5'd1, 32'h101); ret(5'd2, 32'h102); ret(5'd3, 32'h103);
    check("drain_full3", {31'd0, oLdFull}, 32'd0);
    ret(5'd4, 32'h104);
    rd(5'd4, 5'd1);
    check("drain_x4", oRdData[31:0], 32'h104);
    check("drain_busy", {30'd0, oRdBusy}, 32'd0);
    check("err_sticky", {31'd0, oErr}, 32'd1);

    // 5: same-cycle issue and return to busy x9; set wins, count unchanged
    issue(5'd9);
    iLdIssue = 1'b1; iLdDest = 5'd9;
    iWrEn1 = 1'b1; iWrAddr1 = 5'd9; iWrData1 = 32'h99;
    rd(5'd9, 5'd9);
    check("x9_same_byp", oRdData[31:0], 32'h99);
    check("x9_same_busy", {30'd0, oRdBusy}, 32'd0);
    tick(); idle(); #1;
    check("x9_data", oRdData[31:0], 32'h99);
    check("x9_busy_kept", {30'd0, oRdBusy}, 32'd3);
    issue(5'd10); issue(5'd11);
    check("cnt1_full3", {31'd0, oLdFull}, 32'd0);
    issue(5'd13);
    check("cnt1_full4", {31'd0, oLdFull}, 32'd1);
    iWrEn0 = 1'b1; iWrAddr0 = 5'd3; iWrData0 = 32'h11;
    iWrEn1 = 1'b1; iWrAddr1 = 5'd3; iWrData1 = 32'h22;
    rd(5'd3, 5'd3);
    check("x3_dual_byp", oRdData[63:32], 32'h22);
    tick(); idle(); #1;
    check("x3_dual_store", oRdData[31:0], 32'h22);

    // 6: reset discards a concurrent write, then return with count 0
    iRst = 1'b1;
    iWrEn0 = 1'b1; iWrAddr0 = 5'd6; iWrData0 = 32'h66;
    tick(); idle(); iRst = 1'b0;
    rd(5'd6, 5'd9);
    check("rst2_x6", oRdData[31:0], 32'd0);
    check("rst2_x9_busy", {30'd0, oRdBusy}, 32'd0);
    check("rst2_err", {31'd0, oErr}, 32'd0);
    check("rst2_full", {31'd0, oLdFull}, 32'd0);
    iWrEn1 = 1'b1; iWrAddr1 = 5'd12; iWrData1 = 32'hC0FFEE;
    rd(5'd12, 5'd3);
    check("x12_byp", oRdData[31:0], 32'hC0FFEE);
    tick(); idle(); #1;
    check("x12_err", {31'd0, oErr}, 32'd1);
    check("x12_stored", oRdData[31:0], 32'hC0FFEE);

    // reset with two loads pending and an issue in the reset cycle
    issue(5'd14); issue(5'd15);
    rd(5'd14, 5'd15);
    check("pend_busy", {30'd0, oRdBusy}, 32'd3);
    iRst = 1'b1; iLdIssue = 1'b1; iLdDest = 5'd16;
    tick(); idle(); iRst = 1'b0;
    rd(5'd14, 5'd16);
    check("rst3_busy", {30'd0, oRdBusy}, 32'd0);
    check("rst3_err", {31'd0, oErr}, 32'd0);
    check("rst3_full", {31'd0, oLdFull}, 32'd0);
    rd(5'd12, 5'd5);
    check("rst3_x12", oRdData[31:0], 32'd0);
    check("rst3_x5", oRdData[63:32], 32'd0);

    // issues to x0 count but never mark x0 busy
    issue(5'd0); issue(5'd0); issue(5'd0);
    check("x0_full3", {31'd0, oLdFull}, 32'd0);
    rd(5'd0, 5'd0);
    check("x0_busy", {30'd0, oRdBusy}, 32'd0);
    issue(5'd0);
    check("x0_full4", {31'd0, oLdFull}, 32'd1);
    check("x0_err", {31'd0, oErr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
